// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, one block in flight.
// Blocks enter and leave over valid/ready handshakes; key expansion is built in.
module aes_decrypt_iter #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in,
    input  logic [N-1:0]   key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out,
    output logic [1:0]     dbg_state_o
);

    // Handshake contract: a transfer happens on a rising edge where valid and
    // ready are both high. in_ready is high only in IDLE and out_valid only in
    // DONE, both straight from the state register; in_valid is ignored outside
    // IDLE and out_ready outside DONE, and out holds steady while waiting.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int KW = 128 * (Nr + 1);

    // Forward S-box, needed by key expansion only. Byte x sits at [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box used by InvSubBytes.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    state_e         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   out_q, out_d;
    logic [N-1:0]   key_q, key_d;

    logic [N-1:0]   kexp_key;
    logic [KW-1:0]  fullkeys;
    logic [127:0]   rk_last;
    logic [127:0]   rk_rnd;
    logic [127:0]   round_ark;
    logic [127:0]   round_mix;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round key i lands at fk[KW-1-128*i -: 128], so round key 0 is in the MSBs.
    function automatic logic [KW-1:0] key_expansion(input logic [N-1:0] k);
        logic [31:0] w [4*(Nr+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [KW-1:0] fk;
        fk = '0;
        rc = 8'h01;
        for (int i = 0; i < Nk; i++) begin
            w[i] = k[N-1-32*i -: 32];
        end
        for (int i = Nk; i < 4*(Nr+1); i++) begin
            t = w[i-1];
            if (i % Nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
        end
        for (int i = 0; i < 4*(Nr+1); i++) begin
            fk[KW-1-32*i -: 32] = w[i];
        end
        return fk;
    endfunction

    // Byte b of the block is at [127-8*b -: 8], with b = 4*column + row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            r[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                a[j]  = s[127-8*(4*c+j) -: 8];
                x2[j] = xtime(a[j]);
                x4[j] = xtime(x2[j]);
                x8[j] = xtime(x4[j]);
                m9[j] = x8[j] ^ a[j];
                mb[j] = x8[j] ^ x2[j] ^ a[j];
                md[j] = x8[j] ^ x4[j] ^ a[j];
                me[j] = x8[j] ^ x4[j] ^ x2[j];
            end
            r[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            r[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            r[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            r[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return r;
    endfunction

    // Expansion reads the live key input in IDLE so the accept cycle already
    // sees the new last round key; afterwards it reads the registered copy.
    always_comb begin
        kexp_key  = (state_q == IDLE) ? key : key_q;
        fullkeys  = key_expansion(kexp_key);
        rk_last   = fullkeys[127:0];
        rk_rnd    = fullkeys[128*(Nr-int'(rnd_q)) +: 128];
        round_ark = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_rnd;
        round_mix = inv_mix_columns(round_ark);
    end

    // Next-state logic: accept in IDLE, one inverse round per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        out_d   = out_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    key_d   = key;
                    blk_d   = in ^ rk_last;
                    rnd_d   = 4'(Nr - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rnd_q != 4'd0) begin
                    blk_d = round_mix;
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    blk_d   = round_ark;
                    out_d   = round_ark;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, round counter, working block, output and key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            out_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            key_q   <= key_d;
        end
    end

    // out has its own register so it survives later rounds until the next DONE.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        out         = out_q;
        dbg_state_o = state_q;
    end

endmodule
